// File: rtl/nf_cpu2ahb_bridge.sv
// Single-outstanding AHB-Lite master: turns a held CPU req/ack handshake into one SINGLE transfer.
// Optional data-phase timeout abort enabled with `define NF_AHB_TIMEOUT_EN.
module nf_cpu2ahb_bridge #(
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned TO_W        = 4
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        req,
    output logic        req_ack,
    output logic        req_err,
    output logic [31:0] rd,
    output logic [31:0] haddr,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    output logic        hwrite,
    output logic [1:0]  htrans,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    input  logic [1:0]  hresp,
    input  logic        hready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    logic [1:0]  state_q,   state_d;
    logic [31:0] haddr_q,   haddr_d;
    logic [31:0] wd_q,      wd_d;
    logic [31:0] hwdata_q,  hwdata_d;
    logic        hwrite_q,  hwrite_d;
    logic [1:0]  size_q,    size_d;
    logic [1:0]  htrans_q,  htrans_d;
    logic [31:0] rd_q,      rd_d;
    logic        req_ack_q, req_ack_d;
    logic        req_err_q, req_err_d;

`ifdef NF_AHB_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d;
`else
    logic unused_params_c;
    assign unused_params_c = ^{32'(TIMEOUT_CYC), 32'(TO_W)};
`endif

    // Next-state and registered-output decode; every output is loaded one edge ahead of its state.
    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        wd_d      = wd_q;
        hwdata_d  = hwdata_q;
        hwrite_d  = hwrite_q;
        size_d    = size_q;
        htrans_d  = htrans_q;
        rd_d      = rd_q;
        req_ack_d = 1'b0;
        req_err_d = req_err_q;
`ifdef NF_AHB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                req_err_d = 1'b0;
                if (req) begin
                    haddr_d  = addr;
                    wd_d     = wd;
                    hwrite_d = we;
                    size_d   = size;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                htrans_d = HTRANS_IDLE;
                hwdata_d = wd_q;
                state_d  = ST_DATA;
`ifdef NF_AHB_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            ST_DATA: begin
                if (hready) begin
                    if (!hwrite_q) begin
                        rd_d = hrdata;
                    end
                    req_err_d = (hresp == HRESP_ERROR);
                    req_ack_d = 1'b1;
                    state_d   = ST_ACK;
`ifdef NF_AHB_TIMEOUT_EN
                    cnt_d     = '0;
                end else if (cnt_q == TO_W'(TIMEOUT_CYC)) begin
                    // Slave never answered: abort with an error, rd left alone.
                    req_err_d = 1'b1;
                    req_ack_d = 1'b1;
                    state_d   = ST_ACK;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
`endif
                end
            end
            ST_ACK: begin
                req_err_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            haddr_q   <= '0;
            wd_q      <= '0;
            hwdata_q  <= '0;
            hwrite_q  <= 1'b0;
            size_q    <= '0;
            htrans_q  <= HTRANS_IDLE;
            rd_q      <= '0;
            req_ack_q <= 1'b0;
            req_err_q <= 1'b0;
`ifdef NF_AHB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            wd_q      <= wd_d;
            hwdata_q  <= hwdata_d;
            hwrite_q  <= hwrite_d;
            size_q    <= size_d;
            htrans_q  <= htrans_d;
            rd_q      <= rd_d;
            req_ack_q <= req_ack_d;
            req_err_q <= req_err_d;
`ifdef NF_AHB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign haddr   = haddr_q;
    assign hwdata  = hwdata_q;
    assign hwrite  = hwrite_q;
    assign htrans  = htrans_q;
    assign hsize   = {1'b0, size_q};
    assign hburst  = HBURST_SINGLE;
    assign rd      = rd_q;
    assign req_ack = req_ack_q;
    assign req_err = req_err_q;

endmodule

// File: tb/tb_nf_cpu2ahb_bridge.sv
// Self-checking bench for nf_cpu2ahb_bridge: vector table, directed corner sequences, random transfers.
module tb_nf_cpu2ahb_bridge;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] addr, wd, hrdata;
    logic        we, req, hready;
    logic [1:0]  size, hresp;
    logic        req_ack, req_err, hwrite;
    logic [31:0] rd, haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] model_rd;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic [1:0]  size;
        int          nwait;
        logic [31:0] rdata;
        logic        resp_err;
        logic        drop;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [6];

    nf_cpu2ahb_bridge #(.TIMEOUT_CYC(15), .TO_W(4)) dut (
        .hclk(hclk), .hresetn(hresetn), .addr(addr), .wd(wd), .we(we), .size(size),
        .req(req), .req_ack(req_ack), .req_err(req_err), .rd(rd), .haddr(haddr),
        .hwdata(hwdata), .hrdata(hrdata), .hwrite(hwrite), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hresp(hresp), .hready(hready)
    );

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One transfer starting in an IDLE cycle (cycle 0); returns in the ack cycle.
    task automatic xfer(input vec_t v);
        addr = v.addr; wd = v.wd; we = v.we; size = v.size; req = 1'b1;
        hready = 1'b1; hresp = 2'b00;
        step();
        chk("addr_htrans", 32'(htrans), 32'h2);
        chk("addr_haddr", haddr, v.addr);
        chk("addr_hwrite", 32'(hwrite), 32'(v.we));
        chk("addr_hsize", 32'(hsize), 32'({1'b0, v.size}));
        chk("addr_hburst", 32'(hburst), 32'h0);
        chk("addr_ack", 32'(req_ack), 32'h0);
        addr = $urandom; wd = $urandom; we = ~v.we; size = 2'($urandom_range(0, 2));
        if (v.drop) req = 1'b0;
        for (int i = 0; i <= v.nwait; i++) begin
            step();
            chk("data_htrans", 32'(htrans), 32'h0);
            chk("data_hwdata", hwdata, v.wd);
            chk("data_haddr", haddr, v.addr);
            chk("data_hsize", 32'(hsize), 32'({1'b0, v.size}));
            chk("data_ack", 32'(req_ack), 32'h0);
            if (i == v.nwait) begin
                hready = 1'b1; hrdata = v.rdata; hresp = v.resp_err ? 2'b01 : 2'b00;
            end else begin
                hready = 1'b0; hrdata = $urandom; hresp = 2'b01;
            end
        end
        step();
        chk("ack_pulse", 32'(req_ack), 32'h1);
        chk("ack_err", 32'(req_err), 32'(v.exp_err));
        chk("ack_rd", rd, v.exp_rd);
        chk("ack_htrans", 32'(htrans), 32'h0);
        hready = 1'b1; hresp = 2'b00;
    endtask

    task automatic idle_after(input logic [31:0] exp_rd);
        req = 1'b0;
        step();
        chk("post_ack", 32'(req_ack), 32'h0);
        chk("post_err", 32'(req_err), 32'h0);
        chk("post_htrans", 32'(htrans), 32'h0);
        chk("post_rd_hold", rd, exp_rd);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic w, input int n,
                                input logic [31:0] r, input logic e);
        vec_t v;
        v.addr = a; v.wd = $urandom; v.we = w; v.size = 2'($urandom_range(0, 2));
        v.nwait = n; v.rdata = r; v.resp_err = e; v.drop = 1'b0;
        v.exp_rd = w ? model_rd : r;
        v.exp_err = e;
        return v;
    endfunction

    initial begin
        vec_t v, v2;
        int acks;

        tbl[0] = '{32'h10, 32'hA5A5_1234, 1'b1, 2'd2, 0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        tbl[1] = '{32'h20, 32'h0,         1'b0, 2'd2, 3,  32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0};
        tbl[2] = '{32'h30, 32'h1111_2222, 1'b1, 2'd0, 1,  32'hDEAD_0000, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0};
        tbl[3] = '{32'h40, 32'h0,         1'b0, 2'd1, 0,  32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 1'b1};
        tbl[4] = '{32'h44, 32'h0,         1'b0, 2'd2, 2,  32'h0BAD_BEEF, 1'b0, 1'b1, 32'h0BAD_BEEF, 1'b0};
        tbl[5] = '{32'h48, 32'h5555_AAAA, 1'b1, 2'd2, 15, 32'h0,         1'b1, 1'b0, 32'h0BAD_BEEF, 1'b1};

        hresetn = 1'b0; req = 1'b0; addr = '0; wd = '0; we = 1'b0; size = '0;
        hrdata = '0; hresp = 2'b00; hready = 1'b1;
        model_rd = '0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_htrans", 32'(htrans), 32'h0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_rd", rd, 32'h0);
        chk("rst_hwrite", 32'(hwrite), 32'h0);
        chk("rst_hsize", 32'(hsize), 32'h0);
        chk("rst_ack", 32'(req_ack), 32'h0);
        chk("rst_err", 32'(req_err), 32'h0);
        @(negedge hclk) hresetn = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            xfer(tbl[i]);
            model_rd = tbl[i].exp_rd;
            idle_after(model_rd);
        end

        // Back-to-back: req held through ack, second NONSEQ five cycles after the first request.
        v = mk(32'h20, 1'b0, 0, 32'h1111_1111, 1'b0);
        xfer(v);
        model_rd = v.exp_rd;
        v2 = mk(32'h24, 1'b0, 0, 32'h2222_2222, 1'b0);
        addr = v2.addr; req = 1'b1;
        step();
        chk("b2b_gap_htrans", 32'(htrans), 32'h0);
        chk("b2b_gap_ack", 32'(req_ack), 32'h0);
        xfer(v2);
        model_rd = v2.exp_rd;
        idle_after(model_rd);

        // Slave stuck with hready low.
        addr = 32'h50; we = 1'b0; size = 2'd2; req = 1'b1;
        step();
        req = 1'b0; hready = 1'b0; hresp = 2'b00;
`ifdef NF_AHB_TIMEOUT_EN
        acks = 0;
        for (int c = 2; c <= 17; c++) begin
            step();
            if (req_ack) acks++;
        end
        chk("to_early_ack", 32'(acks), 32'h0);
        step();
        chk("to_ack", 32'(req_ack), 32'h1);
        chk("to_err", 32'(req_err), 32'h1);
        chk("to_rd", rd, model_rd);
        hready = 1'b1;
        idle_after(model_rd);
`else
        acks = 0;
        repeat (100) begin
            step();
            if (req_ack) acks++;
        end
        chk("noto_no_ack", 32'(acks), 32'h0);
        hready = 1'b1; hrdata = 32'h7777_8888;
        step();
        chk("noto_ack", 32'(req_ack), 32'h1);
        chk("noto_rd", rd, 32'h7777_8888);
        model_rd = 32'h7777_8888;
        idle_after(model_rd);
`endif

        // Asynchronous reset in the middle of a data phase.
        addr = 32'h60; we = 1'b0; req = 1'b1;
        step();
        hready = 1'b0;
        step();
        hresetn = 1'b0;
        #1;
        chk("mid_rst_htrans", 32'(htrans), 32'h0);
        chk("mid_rst_ack", 32'(req_ack), 32'h0);
        chk("mid_rst_rd", rd, 32'h0);
        chk("mid_rst_haddr", haddr, 32'h0);
        model_rd = '0;
        req = 1'b0; hready = 1'b1;
        @(negedge hclk) hresetn = 1'b1;
        step();
        chk("post_rst_ack", 32'(req_ack), 32'h0);
        v = mk(32'h64, 1'b0, 1, 32'h600D_CAFE, 1'b0);
        xfer(v);
        model_rd = v.exp_rd;
        idle_after(model_rd);

        // Random transfers against the read-data model.
        for (int k = 0; k < 40; k++) begin
            v = mk($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom,
                   ($urandom_range(0, 3) == 0));
            v.drop = 1'($urandom_range(0, 1));
            xfer(v);
            model_rd = v.exp_rd;
            idle_after(model_rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
